// File: rtl/hack_run_pkg.sv
// Shared command/state encodings and half-period helper for the Hack run controller.
package hack_run_pkg;

  typedef enum logic [1:0] {
    OP_STOP    = 2'b00,
    OP_RUN     = 2'b01,
    OP_STEP    = 2'b10,
    OP_CPU_RST = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_HALTING,
    ST_CPURST
  } state_e;

  localparam int unsigned MIN_HALF = 4;

  // Zero selects the default; tiny values are raised so going_to_rise has room.
  function automatic int unsigned eff_half(input int unsigned cfg, input int unsigned dflt);
    if (cfg == 0) return dflt;
    if (cfg < MIN_HALF) return MIN_HALF;
    return cfg;
  endfunction

endpackage

// File: rtl/hack_run_ctrl_div.sv
// Hack clock divider: counts 0..half-1, toggles hack_clk and strobes at terminal count.
module hack_clk_div #(
  parameter int unsigned COUNTER_W = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [COUNTER_W-1:0] half,
  output logic [COUNTER_W-1:0] counter,
  output logic                 hack_clk,
  output logic                 strobe,
  output logic                 going_to_rise,
  output logic                 rise_evt,
  output logic                 fall_evt
);

  logic [COUNTER_W-1:0] counter_q, counter_d;
  logic                 hack_clk_q, hack_clk_d;
  logic                 strobe_q, strobe_d;
  logic                 tc;

  always_comb begin
    tc         = en && (counter_q == half - COUNTER_W'(1));
    counter_d  = counter_q;
    hack_clk_d = hack_clk_q;
    strobe_d   = 1'b0;
    if (clr || !en) begin
      counter_d  = '0;
      hack_clk_d = 1'b0;
    end else if (tc) begin
      counter_d  = '0;
      hack_clk_d = ~hack_clk_q;
      strobe_d   = 1'b1;
    end else begin
      counter_d  = counter_q + COUNTER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter_q  <= '0;
      hack_clk_q <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      counter_q  <= counter_d;
      hack_clk_q <= hack_clk_d;
      strobe_q   <= strobe_d;
    end
  end

  assign counter       = counter_q;
  assign hack_clk      = hack_clk_q;
  assign strobe        = strobe_q;
  assign rise_evt      = tc && !clr && !hack_clk_q;
  assign fall_evt      = tc && !clr && hack_clk_q;
  assign going_to_rise = en && !hack_clk_q && (counter_q == half - COUNTER_W'(3));

endmodule

// File: rtl/hack_run_ctrl.sv
// Run/stop/step/CPU-reset controller for the Hack CPU clock.
// Optional breakpoint halt when HACK_RUN_BREAKPOINT_EN is defined.
module hack_run_ctrl
  import hack_run_pkg::*;
#(
  parameter int unsigned COUNTER_W    = 7,
  parameter int unsigned DEFAULT_HALF = 35,
  parameter int unsigned STEP_W       = 16,
  parameter int unsigned RST_PERIODS  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [COUNTER_W-1:0] cfg_half_period,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [STEP_W-1:0]    cmd_steps,
  output logic                 hack_clk,
  output logic                 strobe,
  output logic                 going_to_rise,
  output logic                 cpu_reset,
  output logic                 running,
  output logic [STEP_W-1:0]    steps_left,
  output logic [31:0]          cycle_count
`ifdef HACK_RUN_BREAKPOINT_EN
  ,
  input  logic                 bp_en,
  input  logic [15:0]          pc,
  input  logic [15:0]          bp_addr,
  output logic                 bp_hit
`endif
);

  localparam int unsigned RC_W = (RST_PERIODS > 1) ? $clog2(RST_PERIODS) : 1;

  state_e               state_q, state_d;
  logic [COUNTER_W-1:0] half_q, half_d, half_new, counter;
  logic [STEP_W-1:0]    steps_left_q, steps_left_d, steps;
  logic [31:0]          cycle_count_q, cycle_count_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic [RC_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic                 pend_q, pend_d;
  op_e                  pend_op_q, pend_op_d, op;
  logic [STEP_W-1:0]    pend_steps_q, pend_steps_d;
  logic                 div_en, div_clr, rise_evt, fall_evt;
  logic                 accept, cmd_go, bp_fire;

`ifdef HACK_RUN_BREAKPOINT_EN
  logic bp_hit_q;
  assign bp_fire = fall_evt && bp_en && (pc == bp_addr) &&
                   (state_q == ST_RUN || state_q == ST_STEP);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bp_hit_q <= 1'b0;
    else          bp_hit_q <= bp_fire;
  end
  assign bp_hit = bp_hit_q;
`else
  assign bp_fire = 1'b0;
`endif

  hack_clk_div #(.COUNTER_W(COUNTER_W)) u_div (
    .clk           (clk),
    .reset_n       (reset_n),
    .en            (div_en),
    .clr           (div_clr),
    .half          (half_q),
    .counter       (counter),
    .hack_clk      (hack_clk),
    .strobe        (strobe),
    .going_to_rise (going_to_rise),
    .rise_evt      (rise_evt),
    .fall_evt      (fall_evt)
  );

  always_comb begin
    cmd_ready = (state_q == ST_IDLE || state_q == ST_RUN || state_q == ST_STEP) && !pend_q;
    accept    = cmd_valid && cmd_ready;
    // A command landing on a toggle is replayed next cycle against the new hack_clk.
    pend_d       = accept && (rise_evt || fall_evt);
    pend_op_d    = pend_d ? op_e'(cmd_op) : pend_op_q;
    pend_steps_d = pend_d ? cmd_steps : pend_steps_q;
    cmd_go    = pend_q || (accept && !pend_d);
    op        = pend_q ? pend_op_q : op_e'(cmd_op);
    steps     = pend_q ? pend_steps_q : cmd_steps;
    half_new  = COUNTER_W'(eff_half(32'(cfg_half_period), DEFAULT_HALF));

    state_d       = state_q;
    half_d        = half_q;
    steps_left_d  = steps_left_q;
    cycle_count_d = cycle_count_q;
    cpu_reset_d   = cpu_reset_q;
    rst_cnt_d     = rst_cnt_q;
    div_en        = (state_q != ST_IDLE);
    div_clr       = 1'b0;

    if (rise_evt && state_q != ST_CPURST) cycle_count_d = cycle_count_q + 32'd1;

    case (state_q)
      ST_IDLE: begin
        if (cmd_go) begin
          case (op)
            OP_RUN: begin
              state_d = ST_RUN;
              half_d  = half_new;
            end
            OP_STEP: begin
              if (steps != '0) begin
                state_d      = ST_STEP;
                steps_left_d = steps;
                half_d       = half_new;
              end
            end
            OP_CPU_RST: begin
              state_d       = ST_CPURST;
              half_d        = half_new;
              cpu_reset_d   = 1'b1;
              rst_cnt_d     = '0;
              cycle_count_d = '0;
              steps_left_d  = '0;
            end
            default: ;
          endcase
        end
      end
      ST_RUN, ST_STEP: begin
        if (cmd_go && op == OP_CPU_RST) begin
          state_d       = ST_CPURST;
          div_clr       = 1'b1;
          cpu_reset_d   = 1'b1;
          rst_cnt_d     = '0;
          cycle_count_d = '0;
          steps_left_d  = '0;
        end else if (cmd_go && op == OP_STOP) begin
          if (!hack_clk && counter < half_q - COUNTER_W'(3)) begin
            state_d = ST_IDLE;
            div_clr = 1'b1;
          end else begin
            state_d = ST_HALTING;
          end
        end else if (bp_fire) begin
          state_d = ST_IDLE;
        end else if (state_q == ST_STEP) begin
          if (rise_evt) steps_left_d = steps_left_q - STEP_W'(1);
          if (fall_evt && steps_left_q == '0) state_d = ST_IDLE;
        end
      end
      ST_HALTING: begin
        if (fall_evt) state_d = ST_IDLE;
      end
      ST_CPURST: begin
        if (fall_evt) begin
          if (rst_cnt_q == RC_W'(RST_PERIODS - 1)) begin
            state_d     = ST_IDLE;
            cpu_reset_d = 1'b0;
          end else begin
            rst_cnt_d = rst_cnt_q + RC_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      half_q        <= COUNTER_W'(DEFAULT_HALF);
      steps_left_q  <= '0;
      cycle_count_q <= '0;
      cpu_reset_q   <= 1'b0;
      rst_cnt_q     <= '0;
      pend_q        <= 1'b0;
      pend_op_q     <= OP_STOP;
      pend_steps_q  <= '0;
    end else begin
      state_q       <= state_d;
      half_q        <= half_d;
      steps_left_q  <= steps_left_d;
      cycle_count_q <= cycle_count_d;
      cpu_reset_q   <= cpu_reset_d;
      rst_cnt_q     <= rst_cnt_d;
      pend_q        <= pend_d;
      pend_op_q     <= pend_op_d;
      pend_steps_q  <= pend_steps_d;
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign running     = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_HALTING);
  assign steps_left  = steps_left_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_hack_run_ctrl.sv
// Self-checking bench for hack_run_ctrl: expected waveforms come from closed-form
// timing of hack_clk edges relative to the accepting clk edge.
module tb_hack_run_ctrl;
  import hack_run_pkg::*;

  localparam int DEF = 35;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  cfg_half_period;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_steps;
  logic        hack_clk, strobe, going_to_rise, cpu_reset, running;
  logic [15:0] steps_left;
  logic [31:0] cycle_count;
`ifdef HACK_RUN_BREAKPOINT_EN
  logic        bp_en = 1'b0;
  logic [15:0] pc, bp_addr = 16'h0;
  logic        bp_hit;
  assign pc = cycle_count[15:0];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cc_base  = 0;

  hack_run_ctrl #(.COUNTER_W(7), .DEFAULT_HALF(DEF), .STEP_W(16), .RST_PERIODS(2)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cfg_half_period (cfg_half_period),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_steps       (cmd_steps),
    .hack_clk        (hack_clk),
    .strobe          (strobe),
    .going_to_rise   (going_to_rise),
    .cpu_reset       (cpu_reset),
    .running         (running),
    .steps_left      (steps_left),
    .cycle_count     (cycle_count)
`ifdef HACK_RUN_BREAKPOINT_EN
    ,
    .bp_en           (bp_en),
    .pc              (pc),
    .bp_addr         (bp_addr),
    .bp_hit          (bp_hit)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int half_of(input int cfg);
    return (cfg == 0) ? DEF : ((cfg < 4) ? 4 : cfg);
  endfunction

  // j = clk edges since the edge that started the divider from counter 0, hack_clk 0.
  function automatic bit f_hk(input int j, input int h);
    return ((j / h) % 2) == 1;
  endfunction
  function automatic bit f_strobe(input int j, input int h);
    return (j > 0) && (j % h == 0);
  endfunction
  function automatic bit f_gtr(input int j, input int h);
    return ((j / h) % 2 == 0) && (j % h == h - 3);
  endfunction
  function automatic int f_rises(input int j, input int h);
    return (j / h + 1) / 2;
  endfunction

  task automatic issue(input op_e op, input int steps);
    chk1("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_steps = 16'(steps);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_then_stop(input int cfg, input int j_acc);
    int h, ev_s, dec, idle, jj;
    bit deferred;
    h = half_of(cfg);
    cfg_half_period = 7'(cfg);
    issue(OP_RUN, 0);
    deferred = ((j_acc - 1) % h) == h - 1;
    ev_s = deferred ? j_acc : j_acc - 1;
    dec  = deferred ? j_acc + 1 : j_acc;
    if (!f_hk(ev_s, h) && (ev_s % h) < h - 3) idle = dec;
    else idle = (dec / (2 * h) + 1) * 2 * h;
    for (int j = 1; j <= idle + 3; j++) begin
      if (j == j_acc) begin
        cmd_valid = 1'b1;
        cmd_op    = OP_STOP;
      end
      tick();
      cmd_valid = 1'b0;
      jj = (j <= idle) ? j : idle;
      chk1("stop_hk", hack_clk, (j <= idle) ? f_hk(j, h) : 1'b0);
      chk1("stop_strobe", strobe, (j <= idle) ? f_strobe(j, h) : 1'b0);
      chk1("stop_gtr", going_to_rise, (j < idle) ? f_gtr(j, h) : 1'b0);
      chk1("stop_running", running, j < idle);
      chk32("stop_cycles", cycle_count, 32'(cc_base + f_rises(jj, h)));
      if (j < j_acc || j >= idle) chk1("stop_ready", cmd_ready, 1'b1);
      else if (j >= dec) chk1("halting_ready", cmd_ready, 1'b0);
    end
    cc_base += f_rises(idle, h);
  endtask

  task automatic step_test(input int cfg, input int n);
    int h, end_e, jj;
    h = half_of(cfg);
    cfg_half_period = 7'(cfg);
    issue(OP_STEP, n);
    end_e = 2 * n * h;
    for (int j = 1; j <= end_e + 2; j++) begin
      tick();
      jj = (j <= end_e) ? j : end_e;
      chk1("step_hk", hack_clk, (j <= end_e) ? f_hk(j, h) : 1'b0);
      chk1("step_strobe", strobe, (j <= end_e) ? f_strobe(j, h) : 1'b0);
      chk1("step_gtr", going_to_rise, (j < end_e) ? f_gtr(j, h) : 1'b0);
      chk1("step_running", running, j < end_e);
      chk32("step_left", 32'(steps_left), 32'(n - f_rises(jj, h)));
      chk32("step_cycles", cycle_count, 32'(cc_base + f_rises(jj, h)));
    end
    cc_base += n;
  endtask

  task automatic cpurst_test(input int cfg, input int j_acc);
    int h, entry, stop, k;
    h = half_of(cfg);
    cfg_half_period = 7'(cfg);
    if (j_acc == 0) begin
      issue(OP_CPU_RST, 0);
      entry = 0;
    end else begin
      issue(OP_RUN, 0);
      entry = (((j_acc - 1) % h) == h - 1) ? j_acc + 1 : j_acc;
    end
    stop = entry + 4 * h;
    for (int j = 1; j <= stop + 2; j++) begin
      if (j_acc != 0 && j == j_acc) begin
        cmd_valid = 1'b1;
        cmd_op    = OP_CPU_RST;
      end
      tick();
      cmd_valid = 1'b0;
      if (j < entry) begin
        chk1("pre_rst_hk", hack_clk, f_hk(j, h));
        chk1("pre_rst_strobe", strobe, f_strobe(j, h));
        chk1("pre_rst_cpu_reset", cpu_reset, 1'b0);
        chk32("pre_rst_cycles", cycle_count, 32'(cc_base + f_rises(j, h)));
      end else begin
        k = j - entry;
        chk1("rst_cpu_reset", cpu_reset, j < stop);
        chk1("rst_hk", hack_clk, (j <= stop) ? f_hk(k, h) : 1'b0);
        chk1("rst_strobe", strobe, (j <= stop) ? f_strobe(k, h) : 1'b0);
        chk1("rst_gtr", going_to_rise, (j < stop) ? f_gtr(k, h) : 1'b0);
        chk1("rst_running", running, 1'b0);
        chk1("rst_ready", cmd_ready, j >= stop);
        chk32("rst_cycles", cycle_count, 32'd0);
        chk32("rst_steps_left", 32'(steps_left), 32'd0);
      end
    end
    cc_base = 0;
  endtask

  initial begin
    int cfg;
    reset_n = 1'b0;
    cfg_half_period = 7'd0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_steps = 16'd0;
    repeat (2) tick();
    chk1("reset_hk", hack_clk, 1'b0);
    chk1("reset_strobe", strobe, 1'b0);
    chk1("reset_cpu_reset", cpu_reset, 1'b0);
    chk1("reset_running", running, 1'b0);
    chk32("reset_steps_left", 32'(steps_left), 32'd0);
    chk32("reset_cycles", cycle_count, 32'd0);
    reset_n = 1'b1;
    tick();
    chk1("idle_gtr", going_to_rise, 1'b0);

    run_then_stop(0, 80);   // default half-period; STOP early in a low phase
    step_test(4, 3);        // three steps at H=4 end 24 clks after accept
    run_then_stop(6, 20);   // STOP mid high phase
    run_then_stop(6, 16);   // STOP at counter==H-3 while low
    run_then_stop(5, 10);   // STOP on the falling terminal count
    run_then_stop(5, 15);   // STOP on the rising terminal count
    cpurst_test(4, 6);      // CPU_RST during RUN
    run_then_stop(2, 7);    // clamp to 4 and halting holdoff
    step_test(7, 0);        // zero-step no-op
    cpurst_test(7, 0);      // CPU_RST from IDLE

    for (int r = 0; r < 8; r++) begin
      cfg = int'($urandom_range(0, 10));
      case ($urandom_range(0, 2))
        0:       run_then_stop(cfg, int'($urandom_range(2, 4 * half_of(cfg))));
        1:       step_test(cfg, int'($urandom_range(0, 3)));
        default: cpurst_test(cfg, int'($urandom_range(0, 3 * half_of(cfg))));
      endcase
    end

`ifdef HACK_RUN_BREAKPOINT_EN
    bp_en   = 1'b1;
    bp_addr = 16'(cc_base + 5);
    cfg_half_period = 7'd4;
    issue(OP_RUN, 0);
    for (int j = 1; j <= 45; j++) begin
      tick();
      chk1("bp_running", running, j < 40);
      chk1("bp_hit", bp_hit, j == 40);
      chk1("bp_hk", hack_clk, (j <= 40) ? f_hk(j, 4) : 1'b0);
    end
    cc_base += 5;
    bp_en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_run_ctrl.md
Name: hack_run_ctrl

Overview:
Run/stop/single-step controller for the Hack CPU clock. It owns the divider that produces hack_clk, strobe and going_to_rise, and gates it by command: free-run, stop on a clean low phase, step N hack cycles, or issue a clocked CPU reset. It sits between the SoC host/debug interface and the Hack CPU, ROM and RAM, and keeps a retired-cycle count.

Parameters:
- COUNTER_W, 7, width of the divider counter.
- DEFAULT_HALF, 35, half-period in clk cycles used when cfg_half_period==0.
- STEP_W, 16, width of the step count.
- RST_PERIODS, 2, number of full hack_clk periods cpu_reset is held for.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_half_period  in  COUNTER_W  half-period in clk cycles; 0 selects DEFAULT_HALF.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_op  in  2  00 STOP, 01 RUN, 10 STEP, 11 CPU_RST.
- cmd_steps  in  STEP_W  number of hack cycles for STEP.
- hack_clk  out  1  divided CPU clock.
- strobe  out  1  one-clk pulse on every hack_clk toggle.
- going_to_rise  out  1  hack_clk rises 2 clk cycles later.
- cpu_reset  out  1  synchronous reset to the Hack CPU.
- running  out  1  high in RUN, STEP or HALTING.
- steps_left  out  STEP_W  remaining STEP cycles.
- cycle_count  out  32  count of hack_clk rising edges; wraps at 2^32.

Behaviour:
Reset values (reset_n low, asynchronous):
- State IDLE; counter, hack_clk, strobe, cpu_reset, steps_left and cycle_count all 0.
- Latched half-period = DEFAULT_HALF.

Divider, enabled only outside IDLE:
- counter counts 0..H-1. At H-1: counter<=0, hack_clk toggles, strobe<=1 for one cycle. Otherwise strobe<=0.
- H = the latched half-period, sampled on every accepted command that leaves IDLE; values 1..3 clamp to 4.
- going_to_rise = enabled && ~hack_clk && counter==H-3 (combinational).
- In IDLE: counter is held at 0 and hack_clk is held at 0.

cmd_ready is 1 in IDLE, RUN and STEP; 0 in HALTING and CPURST.

States:
- IDLE:
  - RUN -> RUN.
  - STEP with cmd_steps>0 -> STEP; steps_left<=cmd_steps. STEP with 0 is accepted as a no-op.
  - STOP is a no-op.
  - CPU_RST -> CPURST.
- RUN / STEP:
  - RUN and STEP commands are accepted and ignored.
  - STOP:
    - If hack_clk==0 and counter<H-3: go to IDLE next cycle; counter cleared, no rise.
    - Otherwise -> HALTING.
  - CPU_RST -> CPURST immediately; hack_clk forced 0, counter cleared.
  - In STEP, steps_left decrements on each rising toggle. After the falling toggle that follows the rise taking steps_left to 0 -> IDLE.
- HALTING: continue until the next falling toggle (1->0), then IDLE.
- CPURST:
  - cpu_reset=1; divider runs from counter=0, hack_clk=0.
  - After RST_PERIODS falling toggles: cpu_reset<=0 -> IDLE.
  - cycle_count and steps_left clear on entry.

Other rules:
- cycle_count increments on each rising toggle, except in CPURST.
- hack_clk never shows a glitch or a shortened high phase; every high phase is exactly H clk cycles.
- Simultaneous cmd accept and terminal count: the toggle happens first, and the command is evaluated against the post-toggle hack_clk the next cycle.

Optional Feature:
HACK_RUN_BREAKPOINT_EN
- Enabled: adds inputs bp_en (1) and pc (16), bp_addr (16), and output bp_hit (1).
  - In RUN or STEP, at a falling toggle with bp_en && pc==bp_addr: go to IDLE and pulse bp_hit for 1 cycle.
  - Breakpoint takes priority over the STEP count.
- Disabled: these ports do not exist and there is no breakpoint logic.

Decomposition:
- Package hack_run_pkg:
  - cmd_op encodings (OP_STOP, OP_RUN, OP_STEP, OP_CPU_RST).
  - State encoding.
  - MIN_HALF=4.
- One sub-module, hack_clk_div: counter, toggle, strobe, going_to_rise, with enable and clear inputs. The FSM lives in hack_run_ctrl.

Test Plan:
1. Reset, then RUN with cfg_half_period=0 -> first rise at clk 35 after accept, then a toggle every 35 clks. going_to_rise fires 2 clks before each rise; strobe fires on every toggle.
2. STEP cmd_steps=3, H=4 -> exactly 3 rising edges and cycle_count=3. Ends in IDLE with hack_clk=0 and steps_left=0, 24 clks after accept.
3. STOP while hack_clk=1 mid-high-phase -> high phase completes its full H cycles and falls, then IDLE. STOP at counter==H-3 while low -> rise and fall complete, then IDLE.
4. CPU_RST during RUN, H=4 -> hack_clk drops to 0 immediately. cpu_reset is held for 2 periods (16 clks), then IDLE with cycle_count=0.
5. cfg_half_period=2 -> clamped to 4. cmd_valid during HALTING is held off (cmd_ready=0) until IDLE.
6. With HACK_RUN_BREAKPOINT_EN: RUN with bp_addr=0x0005 and pc reaching 5 -> halt at that falling edge, bp_hit pulses for 1 clk.
